multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath selects and enables: PC, IR, ALU operand muxes, memory, register-file write, write-back mux.
- Decodes opcode/funct3 from the instruction register, using the same opcode classes the immediate generator recognises.
- Detects illegal instructions and memory-handshake timeouts and parks in TRAP.

Parameters:
- WAIT_MAX, 255: maximum consecutive cycles a memory request may wait for mem_ready before timeout (must be ≥1).
- CNT_W, 8: width of the wait counter; must satisfy 2**CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- mem_ready  in  1  memory accepts/completes the pending request this cycle.
- branch_taken  in  1  comparator result for the current branch; sampled in EXEC.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC this cycle.
- pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=ALU result with bit0 cleared (JALR).
- mem_req  out  1  memory request.
- mem_we  out  1  store; valid only with mem_req.
- addr_sel  out  1  0=PC, 1=ALU result.
- alu_src_a  out  1  0=rs1, 1=PC.
- alu_src_b  out  1  0=rs2, 1=imm.
- alu_op  out  2  00=add, 01=compare, 10=R-type funct decode, 11=I-type funct decode.
- reg_we  out  1  register-file write.
- wb_sel  out  2  0=ALU, 1=mem data, 2=PC+4, 3=imm.
- trap_cause  out  2  0=none, 1=illegal, 2=timeout; sticky.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset: state=FETCH, wait counter=0, trap_cause=0. While reset is high every output is 0, including mem_req. Asserting reset mid-instruction aborts it immediately with no PC or register update.
- Outputs are combinational from the registered state, instr, mem_ready and branch_taken. Anything not listed for a state is 0.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1: ir_we=1, next state DECODE. Otherwise stay.
- DECODE (1 cycle): classify instr. Legal goes to EXEC; illegal goes to TRAP with trap_cause=1.
- Illegal instructions:
  - opcode outside {0000011, 0100011, 1100011, 1101111, 1100111, 0010011, 0110011, 0110111, 0010111};
  - load or store with funct3≠010;
  - branch with funct3 ∈ {010, 011};
  - JALR with funct3≠000.
- EXEC, per class:
  - R-type: alu_op=10.
  - I-ALU: alu_src_b=1, alu_op=11.
  - Load/store/JALR: alu_src_b=1, alu_op=00.
  - AUIPC: alu_src_a=1, alu_src_b=1, alu_op=00.
  - Branch: alu_op=01, pc_we=1, pc_sel=branch_taken?1:0, next state FETCH.
  - Load/store go next to MEM; all others go next to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for stores. Until mem_ready=1 the state and outputs hold stable.
  - Load with ready: next state WB.
  - Store with ready: pc_we=1, pc_sel=0, next state FETCH.
- WB (1 cycle): reg_we=1, pc_we=1, next state FETCH.
  - R/I/AUIPC: wb_sel=0, pc_sel=0.
  - Load: wb_sel=1, pc_sel=0.
  - LUI: wb_sel=3, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2.
- Handshake: a transfer occurs only when mem_req and mem_ready are both 1 in the same cycle. mem_ready while mem_req=0 is ignored.
- Wait counter:
  - increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0;
  - clears on any accepted transfer and on leaving FETCH/MEM;
  - reaching WAIT_MAX with mem_ready still 0 goes to TRAP with trap_cause=2 on the next edge;
  - mem_ready=1 on the same cycle the counter would hit WAIT_MAX wins (transfer accepted, no trap).
- TRAP: all enables 0. Only exit is reset. trap_cause holds.
- Latency with zero-wait memory: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR 4; store 4; load 5. Each memory wait cycle adds 1.
- Exactly one pc_we pulse per retired instruction. No pc_we for an instruction that traps.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, TRAP;
  - opcode localparams;
  - enums for pc_sel, wb_sel, alu_op and trap_cause;
  - instruction-class enum: R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL.
- One combinational sub-module, ctrl_op_class: instr in, class out, implementing the legality rules. The FSM, wait counter and output decode live in multicycle_ctrl.

Test Plan:
- ADD 0x002081B3 with mem_ready tied 1. Expect FETCH→DECODE→EXEC→WB→FETCH. WB shows reg_we=1, wb_sel=0, pc_we=1, pc_sel=0; 4 cycles total.
- LW 0x0002A303 with mem_ready low 3 cycles in MEM. Expect mem_req=1, addr_sel=1, mem_we=0 held for 4 cycles; then WB with wb_sel=1; 8 cycles total.
- BEQ 0x00208463 with branch_taken=1, then again with branch_taken=0. Expect EXEC pc_we=1 with pc_sel=1, then pc_sel=0; reg_we never asserted; 3 cycles each.
- JALR 0x000300E7, then opcode 0x0000007F. Expect JALR WB with wb_sel=2, pc_sel=2. Then DECODE→TRAP with trap_cause=1, no pc_we, outputs 0 until reset.
- WAIT_MAX=4 with mem_ready held 0 in FETCH. Expect TRAP with trap_cause=2 after the counter reaches 4. Repeat with mem_ready=1 on the 4th wait cycle: expect DECODE and no trap.
- Assert reset during the MEM stage of SW 0x0062A023. Expect all outputs 0 immediately and no pc_we pulse. After release: state_o=FETCH and mem_req=1 on the first cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and opcode constants for the multi-cycle RV32I control FSM
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_CMP    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_TIMEOUT = 2'd2
  } trap_cause_t;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I_ALU   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_t;

  function automatic logic is_mem_class(op_class_t c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if;

  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  modport master (
    input  instr, mem_ready, branch_taken,
    output ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, trap_cause, state_o
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, trap_cause, state_o
  );

endinterface

// File: rtl/ctrl_op_class.sv
// rtl/ctrl_op_class.sv - classifies an RV32I instruction and flags illegal encodings
module ctrl_op_class
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_t   op_class
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31:15], instr[11:7]};

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_OP:     op_class = CLS_R;
      OPC_OP_IMM: op_class = CLS_I_ALU;
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      OPC_JAL:    op_class = CLS_JAL;
      // only word-sized memory accesses are supported by this core
      OPC_LOAD:   if (funct3 == 3'b010) op_class = CLS_LOAD;
      OPC_STORE:  if (funct3 == 3'b010) op_class = CLS_STORE;
      OPC_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) op_class = CLS_BRANCH;
      OPC_JALR:   if (funct3 == 3'b000) op_class = CLS_JALR;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-op and memory-timeout traps
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  // the wait cycle that would bring the count to WAIT_MAX is the last one tolerated
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state;
  trap_cause_t      trap_cause;
  logic [CNT_W-1:0] wait_cnt;
  op_class_t        op_class;

  ctrl_op_class u_op_class (
    .instr    (bus.instr),
    .op_class (op_class)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FETCH;
      wait_cnt   <= '0;
      trap_cause <= TRAP_NONE;
    end else begin
      case (state)
        ST_FETCH, ST_MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (state == ST_FETCH)          state <= ST_DECODE;
            else if (op_class == CLS_LOAD)  state <= ST_WB;
            else                            state <= ST_FETCH;
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt   <= '0;
            state      <= ST_TRAP;
            trap_cause <= TRAP_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          if (op_class == CLS_ILLEGAL) begin
            state      <= ST_TRAP;
            trap_cause <= TRAP_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_class == CLS_BRANCH)        state <= ST_FETCH;
          else if (is_mem_class(op_class))   state <= ST_MEM;
          else                               state <= ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= ST_TRAP;
      endcase
    end
  end

  logic    ir_we, pc_we, mem_req, mem_we, addr_sel, alu_src_a, alu_src_b, reg_we;
  pc_sel_t pc_sel;
  alu_op_t alu_op;
  wb_sel_t wb_sel;

  // outputs are forced low while reset is held so nothing leaks during the async assert
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = bus.mem_ready;
        end
        ST_EXEC: begin
          case (op_class)
            CLS_R:     alu_op = ALU_RFUNCT;
            CLS_I_ALU: begin
              alu_src_b = 1'b1;
              alu_op    = ALU_IFUNCT;
            end
            CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = 1'b1;
            CLS_AUIPC: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
            end
            CLS_BRANCH: begin
              alu_op = ALU_CMP;
              pc_we  = 1'b1;
              pc_sel = bus.branch_taken ? PC_IMM : PC_PLUS4;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (op_class == CLS_STORE);
          pc_we    = (op_class == CLS_STORE) && bus.mem_ready;
        end
        ST_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (op_class)
            CLS_LOAD: wb_sel = WB_MEM;
            CLS_LUI:  wb_sel = WB_IMM;
            CLS_JAL: begin
              wb_sel = WB_PC4;
              pc_sel = PC_IMM;
            end
            CLS_JALR: begin
              wb_sel = WB_PC4;
              pc_sel = PC_ALU;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.addr_sel   = addr_sel;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.reg_we     = reg_we;
  assign bus.wb_sel     = wb_sel;
  assign bus.trap_cause = trap_cause;
  assign bus.state_o    = reset ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       src_a;
    logic       src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        bt;
    obs_t        exp;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pc_pulses = 0;
  logic idle_rdy = 1'b0;

  always @(negedge clk) if (bus.pc_we === 1'b1) pc_pulses++;

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_o;     o.ir_we = bus.ir_we;       o.pc_we = bus.pc_we;
    o.pc_sel = bus.pc_sel;  o.mem_req = bus.mem_req;   o.mem_we = bus.mem_we;
    o.addr_sel = bus.addr_sel; o.src_a = bus.alu_src_a; o.src_b = bus.alu_src_b;
    o.alu_op = bus.alu_op;  o.reg_we = bus.reg_we;     o.wb_sel = bus.wb_sel;
    o.cause = bus.trap_cause;
    return o;
  endfunction

  function automatic obs_t f_fetch(logic r);
    obs_t o = '0;
    o.mem_req = 1'b1;
    o.ir_we   = r;
    return o;
  endfunction

  function automatic obs_t f_trap(logic [1:0] c);
    obs_t o = '0;
    o.st    = 3'd5;
    o.cause = c;
    return o;
  endfunction

  task automatic push(input logic [31:0] i, input logic r, input logic b, input obs_t e);
    ent_t x;
    x.instr = i; x.rdy = r; x.bt = b; x.exp = e;
    sb.push_back(x);
  endtask

  // expected cycle-by-cycle outputs for one instruction, from the control table
  task automatic push_seq(input logic [31:0] i, input int k, input int fw, input int mw, input logic bt);
    obs_t e;
    for (int w = 0; w < fw; w++) push(i, 1'b0, 1'b0, f_fetch(1'b0));
    push(i, 1'b1, 1'b0, f_fetch(1'b1));
    e = '0; e.st = 3'd1;
    push(i, idle_rdy, 1'b0, e);
    e = '0; e.st = 3'd2;
    case (k)
      K_R:     e.alu_op = 2'b10;
      K_I:     begin e.src_b = 1'b1; e.alu_op = 2'b11; end
      K_LOAD, K_STORE, K_JALR: e.src_b = 1'b1;
      K_AUIPC: begin e.src_a = 1'b1; e.src_b = 1'b1; end
      K_BR:    begin e.alu_op = 2'b01; e.pc_we = 1'b1; e.pc_sel = {1'b0, bt}; end
      default: ;
    endcase
    push(i, idle_rdy, bt, e);
    if (k == K_BR) return;
    if (k == K_LOAD || k == K_STORE) begin
      e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (k == K_STORE);
      for (int w = 0; w < mw; w++) push(i, 1'b0, 1'b0, e);
      if (k == K_STORE) e.pc_we = 1'b1;
      push(i, 1'b1, 1'b0, e);
      if (k == K_STORE) return;
    end
    e = '0; e.st = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1;
    case (k)
      K_LOAD: e.wb_sel = 2'd1;
      K_LUI:  e.wb_sel = 2'd3;
      K_JAL:  begin e.wb_sel = 2'd2; e.pc_sel = 2'd1; end
      K_JALR: begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
      default: ;
    endcase
    push(i, idle_rdy, 1'b0, e);
  endtask

  task automatic do_reset();
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    idle_rdy = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    bus.instr = 32'h002081B3; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    @(negedge clk);
    got = sample(); checks++;
    if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, obs_t'(0)); end
    @(posedge clk);
    #1 reset = 1'b0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
    @(negedge clk);
    got = sample(); checks++;
    if (got !== f_fetch(1'b0)) begin errors++; $display("FAIL reset_release: got %h want %h", got, f_fetch(1'b0)); end
  endtask

  task automatic test_add();
    ent_t ent; obs_t got; int n = 0; int p0;
    do_reset();
    idle_rdy = 1'b1;
    p0 = pc_pulses;
    push_seq(32'h002081B3, K_R, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL add cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    checks++;
    if (pc_pulses - p0 !== 1) begin errors++; $display("FAIL add_pc_we: got %0d want 1", pc_pulses - p0); end
  endtask

  task automatic test_load_wait();
    ent_t ent; obs_t got; int n = 0;
    do_reset();
    push_seq(32'h0002A303, K_LOAD, 0, 3, 1'b0);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL lw cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL lw_cycles: got %0d want 8", n); end
  endtask

  task automatic test_branch();
    ent_t ent; obs_t got; int n = 0; int p0;
    do_reset();
    p0 = pc_pulses;
    push_seq(32'h00208463, K_BR, 0, 0, 1'b1);
    push_seq(32'h00208463, K_BR, 0, 0, 1'b0);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL beq cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    checks++;
    if (pc_pulses - p0 !== 2) begin errors++; $display("FAIL beq_pc_we: got %0d want 2", pc_pulses - p0); end
  endtask

  task automatic test_jalr_illegal();
    ent_t ent; obs_t got; int n = 0; int p0; obs_t e;
    do_reset();
    p0 = pc_pulses;
    push_seq(32'h000300E7, K_JALR, 0, 0, 1'b0);
    push(32'h0000007F, 1'b1, 1'b0, f_fetch(1'b1));
    e = '0; e.st = 3'd1;
    push(32'h0000007F, 1'b0, 1'b0, e);
    for (int t = 0; t < 3; t++) push(32'h0000007F, 1'b1, 1'b1, f_trap(2'd1));
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL jalr_ill cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    checks++;
    if (pc_pulses - p0 !== 1) begin errors++; $display("FAIL jalr_ill_pc_we: got %0d want 1", pc_pulses - p0); end
  endtask

  task automatic test_illegal_variants();
    ent_t ent; obs_t got; obs_t e;
    logic [31:0] bad [4] = '{32'h00028303, 32'h00629023, 32'h0020A463, 32'h000310E7};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      push(bad[v], 1'b1, 1'b0, f_fetch(1'b1));
      e = '0; e.st = 3'd1;
      push(bad[v], 1'b0, 1'b0, e);
      push(bad[v], 1'b1, 1'b0, f_trap(2'd1));
      while (sb.size() > 0) begin
        ent = sb.pop_front();
        bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
        @(negedge clk);
        got = sample(); checks++;
        if (got !== ent.exp) begin errors++; $display("FAIL illegal_%h: got %h want %h", bad[v], got, ent.exp); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_timeout();
    ent_t ent; obs_t got; int n = 0;
    do_reset();
    for (int w = 0; w < 4; w++) push(32'h002081B3, 1'b0, 1'b0, f_fetch(1'b0));
    for (int t = 0; t < 2; t++) push(32'h002081B3, 1'b1, 1'b0, f_trap(2'd2));
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL timeout cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    do_reset();
    n = 0;
    push_seq(32'h002081B3, K_R, 3, 0, 1'b0);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL ready_at_limit cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    ent_t ent; obs_t got; int n = 0; int p0;
    do_reset();
    p0 = pc_pulses;
    push_seq(32'h00100093, K_I, 1, 0, 1'b0);
    push_seq(32'h123450B7, K_LUI, 0, 0, 1'b0);
    push_seq(32'h00001097, K_AUIPC, 0, 0, 1'b0);
    push_seq(32'h008000EF, K_JAL, 2, 0, 1'b0);
    push_seq(32'h0062A023, K_STORE, 0, 0, 1'b0);
    push_seq(32'h0062A023, K_STORE, 0, 2, 1'b0);
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL b2b cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    checks++;
    if (pc_pulses - p0 !== 6) begin errors++; $display("FAIL b2b_pc_we: got %0d want 6", pc_pulses - p0); end
  endtask

  task automatic test_reset_mid_mem();
    ent_t ent; obs_t got; int n = 0; int p0;
    do_reset();
    push_seq(32'h0062A023, K_STORE, 0, 3, 1'b0);
    void'(sb.pop_back());
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      bus.instr = ent.instr; bus.mem_ready = ent.rdy; bus.branch_taken = ent.bt;
      @(negedge clk);
      got = sample(); checks++;
      if (got !== ent.exp) begin errors++; $display("FAIL sw_pre cyc%0d: got %h want %h", n, got, ent.exp); end
      n++; @(posedge clk); #1;
    end
    p0 = pc_pulses;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== obs_t'(0)) begin errors++; $display("FAIL reset_async: got %h want %h", got, obs_t'(0)); end
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    got = sample(); checks++;
    if (got !== f_fetch(1'b0)) begin errors++; $display("FAIL reset_refetch: got %h want %h", got, f_fetch(1'b0)); end
    checks++;
    if (pc_pulses !== p0) begin errors++; $display("FAIL reset_no_pc_we: got %0d want %0d", pc_pulses, p0); end
  endtask

  initial begin
    reset = 1'b1;
    bus.instr = '0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jalr_illegal();
    test_illegal_variants();
    test_timeout();
    test_back_to_back();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
